// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address match, byte write and byte read.
// The bus inputs are resynchronised to sys_clk. All protocol decisions use
// edges of the resynchronised levels.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN: when it is defined, a
// 3-sample majority-free glitch filter follows the synchronizers. A filtered
// level changes only after 3 consecutive equal samples.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_s;
  logic       sda_s;
  logic       scl_prev_r;
  logic       sda_prev_r;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       rw_r;
  logic       rd_wait_fall_r;

  // Two-flop synchronizers for the asynchronous bus levels, idle-high preset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r;
  logic [1:0] sda_hist_r;
  logic       scl_flt_r;
  logic       sda_flt_r;

  // Filtered level follows only after three consecutive equal samples
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      if (&{scl_hist_r, scl_sync_r[1]}) begin
        scl_flt_r <= 1'b1;
      end else if (~|{scl_hist_r, scl_sync_r[1]}) begin
        scl_flt_r <= 1'b0;
      end else begin
        scl_flt_r <= scl_flt_r;
      end
      if (&{sda_hist_r, sda_sync_r[1]}) begin
        sda_flt_r <= 1'b1;
      end else if (~|{sda_hist_r, sda_sync_r[1]}) begin
        sda_flt_r <= 1'b0;
      end else begin
        sda_flt_r <= sda_flt_r;
      end
    end
  end

  assign scl_s = scl_flt_r;
  assign sda_s = sda_flt_r;
`else
  assign scl_s = scl_sync_r[1];
  assign sda_s = sda_sync_r[1];
`endif

  // Previous conditioned levels for edge and START/STOP detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // SCL must be high on both samples so SDA moves during SCL low never count
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  // Protocol FSM; sda_oe doubles as the phase flag of the ACK clock
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 3'd0;
      shift_r        <= 8'h00;
      rw_r           <= 1'b0;
      rd_wait_fall_r <= 1'b0;
      sda_oe         <= 1'b0;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      tx_load        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 3'd7;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_s) begin
        state_r <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE, WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s) begin
              shift_r <= {shift_r[6:0], sda_s};
              if (bit_cnt_r == 3'd0) begin
                if (shift_r[6:0] == SLAVE_ADDR) begin
                  state_r <= ADDR_ACK;
                  busy    <= 1'b1;
                  rw_r    <= sda_s;
                end else begin
                  state_r <= WAIT_STOP;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                bit_cnt_r <= 3'd7;
                if (rw_r) begin
                  tx_load        <= 1'b1;
                  rd_wait_fall_r <= 1'b0;
                  state_r        <= RD_DATA;
                end else begin
                  state_r <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise_s) begin
              shift_r <= {shift_r[6:0], sda_s};
              if (bit_cnt_r == 3'd0) begin
                rx_data  <= {shift_r[6:0], sda_s};
                rx_valid <= 1'b1;
                state_r  <= WR_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                bit_cnt_r <= 3'd7;
                state_r   <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            // After an ACK clock the load happens with SCL high, so the MSB
            // waits for the next falling edge; after the address it goes out at once
            if (tx_load) begin
              shift_r <= tx_data;
              if (!rd_wait_fall_r) begin
                sda_oe <= ~tx_data[7];
              end
            end else if (scl_fall_s) begin
              if (rd_wait_fall_r) begin
                sda_oe         <= ~shift_r[7];
                rd_wait_fall_r <= 1'b0;
              end else if (bit_cnt_r == 3'd0) begin
                sda_oe  <= 1'b0;
                state_r <= RD_ACK;
              end else begin
                shift_r   <= {shift_r[6:0], 1'b0};
                sda_oe    <= ~shift_r[6];
                bit_cnt_r <= bit_cnt_r - 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise_s) begin
              if (!sda_s) begin
                tx_load        <= 1'b1;
                rd_wait_fall_r <= 1'b1;
                bit_cnt_r      <= 3'd7;
                state_r        <= RD_DATA;
              end else begin
                state_r <= WAIT_STOP;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master with SCL period 40 sys_clk,
// a table of directed transactions, randomized transactions, and hand-written
// repeated-START, glitch and mid-read reset sequences.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int         Q   = 10;
  localparam logic [6:0] OWN = 7'h55;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  always #5 sys_clk = ~sys_clk;

  // Open-drain wired-AND of master and slave
  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(OWN)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .scl_in  (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .busy    (busy)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] tx_arr [0:15];
  logic [7:0] rx_log [0:255];
  logic [7:0] wr_arr [0:3];
  logic [7:0] rd_arr [0:3];
  int         ld_cnt = 0;
  int         rx_cnt = 0;
  int         oe_cnt = 0;
  int         oe_bad = 0;
  logic       oe_d   = 1'b0;
  logic       scl_d  = 1'b1;
  logic       rst_d  = 1'b1;

  // The k-th tx_load returns tx_arr[k mod 16]
  assign tx_data = tx_arr[ld_cnt % 16];

  // Bus monitor: load/byte logging, SDA activity, SDA changes with SCL high
  always @(posedge sys_clk) begin
    if (tx_load) ld_cnt <= ld_cnt + 1;
    if (rx_valid) begin
      rx_log[rx_cnt % 256] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if ((sda_oe !== oe_d) && scl_d && !rst_d && !rst) oe_bad <= oe_bad + 1;
    oe_d  <= sda_oe;
    scl_d <= m_scl;
    rst_d <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    tick(Q); m_sda = b;
    tick(Q); m_scl = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      tick(Q); m_sda = 1'b1;
      tick(Q); m_scl = 1'b1;
    end
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~mack, s);
  endtask

  // Reference rule: only the own address is acknowledged
  function automatic logic model_ack(input logic [6:0] a);
    return a == OWN;
  endfunction

  // One transaction; write data from wr_arr, read data expected from tx_arr
  task automatic run_txn(input string tag, input logic [6:0] a, input logic rw,
                         input int n, input logic exp_ack, input logic do_stop);
    int         rx0, ld0, oe0, exp_rx, exp_ld;
    logic       ack, dk;
    logic [7:0] d;
    rx0 = rx_cnt; ld0 = ld_cnt; oe0 = oe_cnt;
    exp_rx = (exp_ack && !rw) ? n : 0;
    exp_ld = (exp_ack && rw) ? n : 0;
    i2c_start();
    send_byte({a, rw}, ack);
    chk({tag, " addr_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, " busy_at_ack"}, 32'(busy), 32'(exp_ack));
    if (ack) begin
      for (int i = 0; i < n; i++) begin
        if (rw) begin
          recv_byte(i != n - 1, d);
          rd_arr[i] = d;
        end else begin
          send_byte(wr_arr[i], dk);
          chk({tag, " data_ack"}, 32'(dk), 32'd1);
        end
      end
    end
    tick(2);
    chk({tag, " rx_count"}, 32'(rx_cnt - rx0), 32'(exp_rx));
    chk({tag, " load_count"}, 32'(ld_cnt - ld0), 32'(exp_ld));
    for (int i = 0; i < exp_rx; i++)
      chk({tag, " rx_byte"}, 32'(rx_log[(rx0 + i) % 256]), 32'(wr_arr[i]));
    for (int i = 0; i < exp_ld; i++)
      chk({tag, " rd_byte"}, 32'(rd_arr[i]), 32'(tx_arr[(ld0 + i) % 16]));
    if (!exp_ack) chk({tag, " no_sda_drive"}, 32'(oe_cnt - oe0), 32'd0);
    if (do_stop) begin
      i2c_stop();
      chk({tag, " busy_after_stop"}, 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    logic       ack, s, exp_gb;
    logic [6:0] ra;
    logic       rrw;
    int         rn;

    tbl[0] = '{7'h55, 1'b0, 1, 8'h5A, 8'h00, 1'b1};
    tbl[1] = '{7'h0A, 1'b0, 1, 8'h77, 8'h00, 1'b0};
    tbl[2] = '{7'h55, 1'b1, 2, 8'hC3, 8'h3C, 1'b1};
    tbl[3] = '{7'h54, 1'b0, 1, 8'h12, 8'h00, 1'b0};
    tbl[4] = '{7'h56, 1'b1, 1, 8'h34, 8'h00, 1'b0};
    tbl[5] = '{7'h2A, 1'b0, 1, 8'h56, 8'h00, 1'b0};
    tbl[6] = '{7'h55, 1'b0, 2, 8'h00, 8'hFF, 1'b1};
    tbl[7] = '{7'h55, 1'b1, 2, 8'hFF, 8'h00, 1'b1};
    for (int i = 0; i < 16; i++) tx_arr[i] = 8'h00;

    // Reset state
    tick(5);
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset tx_load", 32'(tx_load), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick(5);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].rw) begin
        tx_arr[ld_cnt % 16]       = tbl[v].d0;
        tx_arr[(ld_cnt + 1) % 16] = tbl[v].d1;
      end else begin
        wr_arr[0] = tbl[v].d0;
        wr_arr[1] = tbl[v].d1;
      end
      run_txn($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].rw, tbl[v].n,
              tbl[v].exp_ack, 1'b1);
    end

    // Randomized transactions against the reference rule
    for (int k = 0; k < 12; k++) begin
      ra  = ($urandom_range(0, 1) == 0) ? OWN : 7'($urandom_range(0, 127));
      rrw = 1'($urandom_range(0, 1));
      rn  = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        wr_arr[i] = 8'($urandom);
        tx_arr[(ld_cnt + i) % 16] = 8'($urandom);
      end
      run_txn($sformatf("rnd%0d", k), ra, rrw, rn, model_ack(ra), 1'b1);
    end

    // Write then repeated START into a read, no STOP in between
    wr_arr[0] = 8'h11;
    run_txn("rs_write", OWN, 1'b0, 1, 1'b1, 1'b0);
    tx_arr[ld_cnt % 16] = 8'h96;
    run_txn("rs_read", OWN, 1'b1, 1, 1'b1, 1'b1);
    chk("rs rx_data", 32'(rx_data), 32'h11);

    // One-sys_clk SDA glitch while SCL high in the middle of a write
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_gb = 1'b1;
`else
    exp_gb = 1'b0;
`endif
    i2c_start();
    send_byte(8'hAA, ack);
    chk("glitch addr_ack", 32'(ack), 32'd1);
    tick(Q); m_sda = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b0;
    tick(1); m_sda = 1'b1;
    tick(Q);
    chk("glitch busy", 32'(busy), 32'(exp_gb));
    m_scl = 1'b0;
    i2c_stop();
    chk("glitch busy_after_stop", 32'(busy), 32'd0);

    // Reset pulsed during bit 4 of a read of 8'hC3 (bit 4 = 0, SDA driven)
    tx_arr[ld_cnt % 16] = 8'hC3;
    i2c_start();
    send_byte(8'hAB, ack);
    chk("rstrd addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) bit_io(1'b1, s);
    tick(Q); m_sda = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(Q);
    chk("rstrd driving bit4", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rstrd sda_oe", 32'(sda_oe), 32'd0);
    chk("rstrd busy", 32'(busy), 32'd0);
    chk("rstrd rx_valid", 32'(rx_valid), 32'd0);
    chk("rstrd tx_load", 32'(tx_load), 32'd0);
    chk("rstrd rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick(Q); m_scl = 1'b0;
    for (int i = 0; i < 3; i++) bit_io(1'b1, s);
    chk("rstrd ignores bus", 32'(sda_oe), 32'd0);
    i2c_stop();
    wr_arr[0] = 8'hE7;
    run_txn("post_reset", OWN, 1'b0, 1, 1'b1, 1'b1);

    chk("sda changes with scl high", 32'(oe_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
